alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Upstream issue stage for the ALU. Accepts operation requests on a valid/ready port and
//  buffers them in a small FIFO. Drives the ALU input pins one operation at a time: CE pulse,
//  then CE=0 hold while the result settles. Pulses EXP_VALID in the cycle the ALU's RES/flags
//  are valid, so the downstream result collector or scoreboard samples exactly once per op.
// PARAMETERS
//  DW       8   operand width (OPA/OPB)
//  CW       4   command width (CMD)
//  DEPTH    4   request FIFO depth, power of 2, >=2
//  BASE_LAT 1   ALU result latency in cycles for non-multiply commands, >=1
//  MUL_LAT  2   ALU result latency in cycles for multiply commands (MODE=1, CMD 9 or 10), >=1
// PORTS
//  CLK            in   1    clock, rising edge
//  RST            in   1    asynchronous reset, active-low
//  FLUSH          in   1    synchronous: empty FIFO, abort in-flight op
//  REQ_VALID      in   1    request present
//  REQ_READY      out  1    FIFO can accept (= !full)
//  REQ_MODE       in   1    1 = arithmetic, 0 = logical
//  REQ_CMD        in   CW   ALU command
//  REQ_INP_VALID  in   2    operand-valid code passed through to the ALU
//  REQ_OPA        in   DW   operand A
//  REQ_OPB        in   DW   operand B
//  REQ_CIN        in   1    carry in
//  CE             out  1    ALU clock enable, 1 for exactly one cycle per op
//  MODE           out  1    to ALU
//  CMD            out  CW   to ALU
//  INP_VALID      out  2    to ALU
//  OPA            out  DW   to ALU
//  OPB            out  DW   to ALU
//  CIN            out  1    to ALU
//  EXP_VALID      out  1    one-cycle pulse: ALU RES/ERR/COUT/OFLOW/G/L/E are valid this cycle
//  BUSY           out  1    FIFO non-empty or state != IDLE
//  ISSUE_CNT      out  16   count of ops issued (CE pulses), wraps 16'hFFFF -> 0
// BEHAVIOUR
//  - Reset values: all outputs 0, REQ_READY 1, FIFO empty, state IDLE.
//  - All ALU-side outputs are registered.
//  - Accept: the request is pushed when REQ_VALID && REQ_READY at a rising edge.
//  - REQ_READY = !full, with no same-cycle bypass when full.
//  - FSM states IDLE, ISSUE, WAIT.
//    IDLE -> ISSUE when the FIFO is non-empty. The head entry is popped on that edge.
//    ISSUE (1 cycle): CE=1; MODE/CMD/INP_VALID/OPA/OPB/CIN carry the popped entry; ISSUE_CNT++.
//    ISSUE -> WAIT. The wait counter is loaded with LAT = MUL_LAT if the op is a multiply,
//      else BASE_LAT.
//    WAIT: CE=0; fields hold the issued values. The counter decrements every cycle.
//    EXP_VALID=1 in the cycle exactly LAT cycles after the CE cycle (CE in cycle C ->
//      EXP_VALID in cycle C+LAT).
//    From that cycle: -> ISSUE if the FIFO is non-empty (pop on same edge), else -> IDLE.
//    Back-to-back throughput is therefore one op per LAT cycles.
//  - IDLE: CE=0, INP_VALID=2'b00; other ALU fields hold their last issued values.
//  - Empty request on arrival: a request entering an empty FIFO while IDLE gives CE=1 two
//    cycles after acceptance (push edge, then pop edge).
//  - FLUSH (priority over push/pop): FIFO emptied, state -> IDLE, CE=0, INP_VALID=00.
//    No EXP_VALID for the aborted op. A push in the same cycle is dropped. ISSUE_CNT unchanged.
//  - Simultaneous push and pop when non-full: both happen and the count is unchanged.
//  - Simultaneous push and pop when full: REQ_READY=0, so only the pop happens.
//  - Wrap: FIFO pointers are log2(DEPTH)+1 bits; full/empty are decided by MSB compare.
//  - RST mid-operation: immediate return to reset values. The in-flight op is lost.
//  - The ALU's ERR is not examined. An INP_VALID=00 request is issued and timed as any other.
// STRUCTURE
//  - alu_pkg (shared):
//    DW/CW defaults, the 2-bit INP_VALID codes, the multiply command constants (9, 10),
//    an issue_state_t enum {IDLE, ISSUE, WAIT}, and an alu_req_t struct
//    {mode, cmd, inp_valid, opa, opb, cin}.
//  - Sub-module alu_req_fifo:
//    synchronous FIFO of alu_req_t with parameter DEPTH, ports push/pop/flush/full/empty and
//    async active-low RST.
//  - The top of this block holds the FSM, the latency counter and the output registers.
// TESTING
//  1 Reset: assert RST=0 mid-WAIT -> all outputs 0 and REQ_READY=1 immediately;
//    after release, no EXP_VALID.
//  2 Single add: MODE=1 CMD=0 OPA=8'h05 OPB=8'h03 CIN=0 INP_VALID=11 accepted at cycle 0
//    -> CE=1 in cycle 2 with those fields, EXP_VALID in cycle 3, ALU RES=9'h008, ISSUE_CNT=1.
//  3 Multiply latency: MODE=1 CMD=9 OPA=8'h03 OPB=8'h04 -> EXP_VALID exactly 2 cycles after CE.
//    A following logical AND (MODE=0 CMD=0, 8'hF0 & 8'h3C) -> CE in the EXP_VALID cycle,
//    and RES=8'h30 one cycle later.
//  4 Full FIFO: hold REQ_VALID for 6 distinct ops while the first op is in WAIT -> REQ_READY
//    drops after 4 buffered ops. All accepted ops issue in order with no loss or duplication;
//    count CE == count EXP_VALID == accepted ops.
//  5 Flush: FLUSH=1 during WAIT with 3 ops queued -> no EXP_VALID, BUSY=0 next cycle,
//    ISSUE_CNT unchanged, the next new request issues normally.
//  6 Counter wrap: preload by issuing 65536 back-to-back ops (or use a forced start near max)
//    -> ISSUE_CNT goes 16'hFFFF -> 16'h0000 on the next CE.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue stage: operand/command widths,
// operand-valid codes, multiply command numbers, FSM states and the request record.
package alu_pkg;

  localparam int DW = 8;
  localparam int CW = 4;

  typedef enum logic [1:0] {
    IV_NONE = 2'b00,
    IV_A    = 2'b01,
    IV_B    = 2'b10,
    IV_AB   = 2'b11
  } inp_valid_e;

  localparam logic [CW-1:0] CMD_MUL_INC = 4'd9;
  localparam logic [CW-1:0] CMD_MUL_SHL = 4'd10;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } issue_state_t;

  typedef struct packed {
    logic          mode;
    logic [CW-1:0] cmd;
    logic [1:0]    inp_valid;
    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
    logic          cin;
  } alu_req_t;

  // Multiplies are the only arithmetic commands with the longer ALU latency.
  function automatic logic is_mul(input logic mode, input logic [CW-1:0] cmd);
    return mode && ((cmd == CMD_MUL_INC) || (cmd == CMD_MUL_SHL));
  endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// Request buffer in front of the ALU issue FSM. Pointers carry one extra wrap bit
// so full and empty are told apart by comparing the MSBs.
module alu_req_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     flush_i,
  input  logic     push_i,
  input  logic     pop_i,
  input  alu_req_t data_i,
  output alu_req_t data_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  alu_req_t    mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; flush wins over any push or pop in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Pointer registers, cleared by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset since the pointers gate every read.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue stage: buffers requests, drives the ALU pins one op at a time with a
// single-cycle CE, and pulses EXP_VALID in the cycle the ALU result is valid.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int BASE_LAT = 1,
  parameter int MUL_LAT  = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_mode_i,
  input  logic [CW-1:0] req_cmd_i,
  input  logic [1:0]    req_inp_valid_i,
  input  logic [DW-1:0] req_opa_i,
  input  logic [DW-1:0] req_opb_i,
  input  logic          req_cin_i,
  output logic          ce_o,
  output logic          mode_o,
  output logic [CW-1:0] cmd_o,
  output logic [1:0]    inp_valid_o,
  output logic [DW-1:0] opa_o,
  output logic [DW-1:0] opb_o,
  output logic          cin_o,
  output logic          exp_valid_o,
  output logic          busy_o,
  output logic [15:0]   issue_cnt_o
);

  issue_state_t state_q, state_d;
  logic [7:0]   rem_q, rem_d;
  logic         ce_q, ce_d;
  logic         exp_q, exp_d;
  alu_req_t     req_q, req_d;
  logic [15:0]  cnt_q, cnt_d;
  logic         start;

  alu_req_t     fifo_in, fifo_head;
  logic         fifo_full, fifo_empty;

  // Cycles from the CE cycle to the cycle the ALU result is valid.
  function automatic logic [7:0] lat_of(input alu_req_t r);
    return is_mul(r.mode, r.cmd) ? 8'(MUL_LAT) : 8'(BASE_LAT);
  endfunction

  assign fifo_in = '{mode: req_mode_i, cmd: req_cmd_i, inp_valid: req_inp_valid_i,
                     opa: req_opa_i, opb: req_opb_i, cin: req_cin_i};

  alu_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (req_valid_i),
    .pop_i   (start),
    .data_i  (fifo_in),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Next state: rem_q counts edges left until the result cycle; the edge that
  // enters the result cycle may also pop the next op so CE lands on EXP_VALID.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    ce_d    = 1'b0;
    exp_d   = 1'b0;
    req_d   = req_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    if (flush_i) begin
      state_d         = IDLE;
      req_d.inp_valid = IV_NONE;
    end else begin
      unique case (state_q)
        IDLE: start = !fifo_empty;
        ISSUE, WAIT: begin
          if (rem_q <= 8'd1) begin
            exp_d = 1'b1;
            if (!fifo_empty) begin
              start = 1'b1;
            end else begin
              state_d         = IDLE;
              req_d.inp_valid = IV_NONE;
            end
          end else begin
            rem_d   = rem_q - 8'd1;
            state_d = WAIT;
          end
        end
        default: state_d = IDLE;
      endcase
      if (start) begin
        state_d = ISSUE;
        ce_d    = 1'b1;
        req_d   = fifo_head;
        cnt_d   = cnt_q + 16'd1;
        rem_d   = lat_of(fifo_head);
      end
    end
  end

  // State, counters and registered ALU-side outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rem_q   <= '0;
      ce_q    <= 1'b0;
      exp_q   <= 1'b0;
      req_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ce_q    <= ce_d;
      exp_q   <= exp_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready_o = !fifo_full;
  assign ce_o        = ce_q;
  assign mode_o      = req_q.mode;
  assign cmd_o       = req_q.cmd;
  assign inp_valid_o = req_q.inp_valid;
  assign opa_o       = req_q.opa;
  assign opb_o       = req_q.opb;
  assign cin_o       = req_q.cin;
  assign exp_valid_o = exp_q;
  assign busy_o      = !fifo_empty || (state_q != IDLE);
  assign issue_cnt_o = cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: table of single ops plus hand-written
// sequences for back-to-back issue, reset, full FIFO, flush and counter wrap.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int DEPTH    = 4;
  localparam int BASE_LAT = 1;
  localparam int MUL_LAT  = 2;

  logic          clk, rstN, flush, reqValid, reqReady;
  logic          reqMode, reqCin;
  logic [CW-1:0] reqCmd;
  logic [1:0]    reqInpValid;
  logic [DW-1:0] reqOpa, reqOpb;
  logic          ce, mode, cin, expValid, busy;
  logic [CW-1:0] cmd;
  logic [1:0]    inpValid;
  logic [DW-1:0] opa, opb;
  logic [15:0]   issueCnt;

  int            checks = 0;
  int            failures = 0;
  logic [15:0]   expCnt = '0;

  typedef struct {
    string    name;
    alu_req_t req;
    int       expLat;
  } vec_t;

  vec_t vecs[6];

  alu_issue_ctrl #(.DEPTH(DEPTH), .BASE_LAT(BASE_LAT), .MUL_LAT(MUL_LAT)) dut (
    .clk_i           (clk),
    .rst_ni          (rstN),
    .flush_i         (flush),
    .req_valid_i     (reqValid),
    .req_ready_o     (reqReady),
    .req_mode_i      (reqMode),
    .req_cmd_i       (reqCmd),
    .req_inp_valid_i (reqInpValid),
    .req_opa_i       (reqOpa),
    .req_opb_i       (reqOpb),
    .req_cin_i       (reqCin),
    .ce_o            (ce),
    .mode_o          (mode),
    .cmd_o           (cmd),
    .inp_valid_o     (inpValid),
    .opa_o           (opa),
    .opb_o           (opb),
    .cin_o           (cin),
    .exp_valid_o     (expValid),
    .busy_o          (busy),
    .issue_cnt_o     (issueCnt)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic alu_req_t mkReq(input logic m, input logic [CW-1:0] c, input logic [1:0] iv,
                                     input logic [DW-1:0] a, input logic [DW-1:0] b, input logic ci);
    alu_req_t r;
    r.mode = m; r.cmd = c; r.inp_valid = iv; r.opa = a; r.opb = b; r.cin = ci;
    return r;
  endfunction

  function automatic alu_req_t observed();
    return alu_req_t'({mode, cmd, inpValid, opa, opb, cin});
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic driveReq(input alu_req_t r);
    reqMode = r.mode; reqCmd = r.cmd; reqInpValid = r.inp_valid;
    reqOpa = r.opa; reqOpb = r.opb; reqCin = r.cin;
  endtask

  // One op from an idle DUT: CE two cycles after acceptance, EXP_VALID LAT later.
  task automatic applyStimulus(input vec_t v);
    int k;
    int ceExtra;
    k = 0;
    ceExtra = 0;
    @(negedge clk);
    checkOutput({v.name, " ready"}, 32'(reqReady), 32'd1);
    driveReq(v.req);
    reqValid = 1'b1;
    @(negedge clk);
    reqValid = 1'b0;
    checkOutput({v.name, " ce early"}, 32'(ce), 32'd0);
    @(negedge clk);
    expCnt++;
    checkOutput({v.name, " ce"}, 32'(ce), 32'd1);
    checkOutput({v.name, " fields"}, 32'(observed()), 32'(v.req));
    checkOutput({v.name, " count"}, 32'(issueCnt), 32'(expCnt));
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (expValid) begin
        k = i;
        break;
      end
      if (ce) ceExtra++;
    end
    checkOutput({v.name, " latency"}, 32'(k), 32'(v.expLat));
    checkOutput({v.name, " ce during wait"}, 32'(ceExtra), 32'd0);
    checkOutput({v.name, " idle inp_valid"}, 32'(inpValid), 32'd0);
    checkOutput({v.name, " opa held"}, 32'(opa), 32'(v.req.opa));
    checkOutput({v.name, " busy at result"}, 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput({v.name, " single exp"}, 32'(expValid), 32'd0);
  endtask

  initial begin
    alu_req_t q[$];
    alu_req_t cur;
    alu_req_t mulOp, andOp;
    int  accepted, ceCount, expCount;
    bit  sawBlock, done, sawExp, wrapped;

    rstN = 1'b0; flush = 1'b0; reqValid = 1'b0;
    driveReq('0);

    vecs[0] = '{name: "add",     req: mkReq(1'b1, 4'd0,  2'b11, 8'h05, 8'h03, 1'b0), expLat: 1};
    vecs[1] = '{name: "mul9",    req: mkReq(1'b1, 4'd9,  2'b11, 8'h03, 8'h04, 1'b0), expLat: 2};
    vecs[2] = '{name: "mul10",   req: mkReq(1'b1, 4'd10, 2'b11, 8'h07, 8'h02, 1'b1), expLat: 2};
    vecs[3] = '{name: "logic9",  req: mkReq(1'b0, 4'd9,  2'b11, 8'hAA, 8'h55, 1'b0), expLat: 1};
    vecs[4] = '{name: "arith11", req: mkReq(1'b1, 4'd11, 2'b01, 8'h80, 8'h7F, 1'b1), expLat: 1};
    vecs[5] = '{name: "iv00",    req: mkReq(1'b1, 4'd2,  2'b00, 8'h12, 8'h34, 1'b0), expLat: 1};

    // Reset values.
    repeat (3) @(negedge clk);
    checkOutput("reset ce", 32'(ce), 32'd0);
    checkOutput("reset exp", 32'(expValid), 32'd0);
    checkOutput("reset ready", 32'(reqReady), 32'd1);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset count", 32'(issueCnt), 32'd0);
    checkOutput("reset fields", 32'(observed()), 32'd0);
    rstN = 1'b1;

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Multiply followed by AND: next CE lands in the multiply's result cycle.
    mulOp = mkReq(1'b1, 4'd9, 2'b11, 8'h03, 8'h04, 1'b0);
    andOp = mkReq(1'b0, 4'd0, 2'b11, 8'hF0, 8'h3C, 1'b0);
    @(negedge clk); driveReq(mulOp); reqValid = 1'b1;
    @(negedge clk); driveReq(andOp); reqValid = 1'b1;
    @(negedge clk); reqValid = 1'b0;
    expCnt++;
    checkOutput("mulAnd mul ce", 32'(ce), 32'd1);
    checkOutput("mulAnd mul fields", 32'(observed()), 32'(mulOp));
    @(negedge clk);
    checkOutput("mulAnd wait ce", 32'(ce), 32'd0);
    checkOutput("mulAnd wait exp", 32'(expValid), 32'd0);
    @(negedge clk);
    expCnt++;
    checkOutput("mulAnd mul exp", 32'(expValid), 32'd1);
    checkOutput("mulAnd and ce", 32'(ce), 32'd1);
    checkOutput("mulAnd and fields", 32'(observed()), 32'(andOp));
    checkOutput("mulAnd count", 32'(issueCnt), 32'(expCnt));
    @(negedge clk);
    checkOutput("mulAnd and exp", 32'(expValid), 32'd1);
    checkOutput("mulAnd and ce off", 32'(ce), 32'd0);
    checkOutput("mulAnd idle inp_valid", 32'(inpValid), 32'd0);
    @(negedge clk);
    checkOutput("mulAnd quiet", 32'(expValid), 32'd0);
    checkOutput("mulAnd busy", 32'(busy), 32'd0);

    // Reset asserted in the WAIT cycle of a multiply.
    @(negedge clk); driveReq(mulOp); reqValid = 1'b1;
    @(negedge clk); reqValid = 1'b0;
    @(negedge clk);
    checkOutput("rstWait ce", 32'(ce), 32'd1);
    @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("rstWait ce", 32'(ce), 32'd0);
    checkOutput("rstWait exp", 32'(expValid), 32'd0);
    checkOutput("rstWait ready", 32'(reqReady), 32'd1);
    checkOutput("rstWait busy", 32'(busy), 32'd0);
    checkOutput("rstWait count", 32'(issueCnt), 32'd0);
    checkOutput("rstWait fields", 32'(observed()), 32'd0);
    expCnt = '0;
    @(negedge clk);
    rstN = 1'b1;
    sawExp = 1'b0;
    repeat (4) begin
      @(negedge clk);
      sawExp |= expValid;
    end
    checkOutput("rstWait no exp after release", 32'(sawExp), 32'd0);

    // Back-to-back multiplies held on the port until the FIFO fills.
    accepted = 0; ceCount = 0; expCount = 0; sawBlock = 1'b0; done = 1'b0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      @(negedge clk);
      if (ce) begin
        ceCount++;
        expCnt++;
        if (q.size() == 0) begin
          checkOutput("fifo spurious issue", 32'd1, 32'd0);
        end else begin
          checkOutput("fifo order", 32'(observed()), 32'(q.pop_front()));
          checkOutput("fifo count", 32'(issueCnt), 32'(expCnt));
        end
      end
      if (expValid) expCount++;
      if (accepted < 10) begin
        cur = mkReq(1'b1, 4'd9, 2'b11, 8'(accepted * 17 + 1), 8'(accepted), accepted[0]);
        driveReq(cur);
        reqValid = 1'b1;
        if (reqReady) begin
          q.push_back(cur);
          accepted++;
        end else if (!sawBlock) begin
          sawBlock = 1'b1;
          checkOutput("fifo depth at block", 32'(accepted - ceCount), 32'(DEPTH));
        end
      end else begin
        reqValid = 1'b0;
        if (!busy) done = 1'b1;
      end
    end
    reqValid = 1'b0;
    checkOutput("fifo drained", 32'(done), 32'd1);
    checkOutput("fifo ready dropped", 32'(sawBlock), 32'd1);
    checkOutput("fifo ce total", 32'(ceCount), 32'd10);
    checkOutput("fifo exp total", 32'(expCount), 32'd10);
    checkOutput("fifo leftovers", 32'(q.size()), 32'd0);

    // Flush during WAIT with three ops queued.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 2 || i == 4) begin
        expCnt++;
        checkOutput("flush setup ce", 32'(ce), 32'd1);
      end
      if (i == 4) checkOutput("flush first exp", 32'(expValid), 32'd1);
      driveReq(mkReq(1'b1, 4'd9, 2'b11, 8'(8'h10 + i), 8'h02, 1'b0));
      reqValid = 1'b1;
    end
    @(negedge clk);
    reqValid = 1'b0;
    checkOutput("flush pre ce", 32'(ce), 32'd0);
    checkOutput("flush pre busy", 32'(busy), 32'd1);
    checkOutput("flush pre count", 32'(issueCnt), 32'(expCnt));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush exp", 32'(expValid), 32'd0);
    checkOutput("flush busy", 32'(busy), 32'd0);
    checkOutput("flush ce", 32'(ce), 32'd0);
    checkOutput("flush inp_valid", 32'(inpValid), 32'd0);
    checkOutput("flush count", 32'(issueCnt), 32'(expCnt));
    checkOutput("flush ready", 32'(reqReady), 32'd1);
    @(negedge clk);
    checkOutput("flush later exp", 32'(expValid), 32'd0);
    checkOutput("flush later ce", 32'(ce), 32'd0);
    applyStimulus('{name: "postFlush", req: mkReq(1'b1, 4'd1, 2'b11, 8'h21, 8'h09, 1'b1), expLat: 1});

    // Issue counter wrap with a continuous stream of single-cycle ops.
    wrapped = 1'b0;
    driveReq(vecs[0].req);
    reqValid = 1'b1;
    for (int cyc = 0; cyc < 70000 && !wrapped; cyc++) begin
      @(negedge clk);
      if (ce) begin
        expCnt++;
        if (expCnt == 16'hFFFF) begin
          checkOutput("count max", 32'(issueCnt), 32'h0000FFFF);
        end else if (expCnt == 16'h0000) begin
          checkOutput("count wrap", 32'(issueCnt), 32'd0);
          wrapped = 1'b1;
        end
      end
    end
    reqValid = 1'b0;
    checkOutput("count wrap reached", 32'(wrapped), 32'd1);
    done = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    checkOutput("final drain", 32'(done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
